spi_reg_bridge: RTL and testbench

SPI mode-0 slave that converts byte-framed SPI transactions into the 3-bit-address / 8-bit-data register bus consumed by the LED driver and the other spi2gpio peripherals. SCLK, CS_n and MOSI are oversampled in the system clock domain. Writes become single-cycle active-low write strobes. Reads return the peripheral's combinational read data on MISO. Burst transfers auto-increment the address.

---
 rtl/spi_reg_bridge_if.sv | 26 ++
 rtl/spi_reg_bridge.sv | 167 ++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bridge_if.sv
// SPI pad signals and the 3-bit-address register bus shared by the bridge and its peripherals.
// The slave modport is the bridge's view; the master modport is the pads plus downstream register file.
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              i_sclk;
    logic              i_cs_n;
    logic              i_mosi;
    logic              o_miso;
    logic              o_wr_n;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              o_busy;

    modport slave (
        input  i_sclk, i_cs_n, i_mosi, i_rdata,
        output o_miso, o_wr_n, o_addr, o_wdata, o_busy
    );

    modport master (
        output i_sclk, i_cs_n, i_mosi, i_rdata,
        input  o_miso, o_wr_n, o_addr, o_wdata, o_busy
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave turning byte-framed transactions (command byte, then data bytes)
// into single-cycle register writes or MISO read-back, with burst address auto-increment.
module spi_reg_bridge #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8,
    parameter int BIT_CNT_W = 3
) (
    input logic             i_clk,
    input logic             i_rst,
    spi_reg_bridge_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    logic sclk_meta, sclk_sync, sclk_hist;
    logic cs_meta, cs_sync, cs_hist;
    logic mosi_meta, mosi_sync;

    logic [1:0]           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-2:0]    shift_reg;
    logic [DATA_W-1:0]    tx_reg;
    logic [DATA_W-1:0]    next_byte;
    logic                 is_write;
    logic                 load_tx;
    logic [1:0]           flush_cnt;
    logic                 armed;
    logic                 sclk_rise, sclk_fall;

    logic              miso_q;
    logic              wr_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;

    assign sclk_rise = sclk_sync & ~sclk_hist;
    assign sclk_fall = ~sclk_sync & sclk_hist;
    assign next_byte = {shift_reg, mosi_sync};

    // After reset the CS chain holds its forced-high value for a few cycles, so a frame may only
    // start once CS has genuinely been seen high (armed); a reset in mid-frame waits for a fresh CS toggle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_hist <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_hist   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_reg    <= '0;
            is_write  <= 1'b0;
            load_tx   <= 1'b0;
            flush_cnt <= 2'd0;
            armed     <= 1'b0;
            miso_q    <= 1'b0;
            wr_n_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            sclk_meta <= bus.i_sclk;
            sclk_sync <= sclk_meta;
            sclk_hist <= sclk_sync;
            cs_meta   <= bus.i_cs_n;
            cs_sync   <= cs_meta;
            cs_hist   <= cs_sync;
            mosi_meta <= bus.i_mosi;
            mosi_sync <= mosi_meta;

            if (flush_cnt != 2'd3) begin
                flush_cnt <= flush_cnt + 2'd1;
            end
            if (flush_cnt == 2'd3 && cs_sync && cs_hist) begin
                armed <= 1'b1;
            end

            load_tx <= 1'b0;

            // The strobe lasts one cycle; the address steps only once the strobe has been seen.
            if (!wr_n_q) begin
                wr_n_q <= 1'b1;
                addr_q <= addr_q + ADDR_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    miso_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    if (armed && !cs_sync) begin
                        state  <= ST_CMD;
                        busy_q <= 1'b1;
                    end
                end

                ST_CMD: begin
                    if (cs_sync) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        bit_cnt <= '0;
                    end else if (sclk_rise) begin
                        shift_reg <= next_byte[DATA_W-2:0];
                        bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            is_write <= next_byte[DATA_W-1];
                            addr_q   <= next_byte[ADDR_W-1:0];
                            load_tx  <= ~next_byte[DATA_W-1];
                            state    <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (cs_sync) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        bit_cnt <= '0;
                        miso_q  <= 1'b0;
                    end else if (is_write) begin
                        if (sclk_rise) begin
                            shift_reg <= next_byte[DATA_W-2:0];
                            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                wdata_q <= next_byte;
                                wr_n_q  <= 1'b0;
                            end
                        end
                    end else begin
                        // Read data arrives one cycle after the address moves; each fall presents the next MSB.
                        if (load_tx) begin
                            tx_reg <= bus.i_rdata;
                        end
                        if (sclk_fall) begin
                            miso_q <= tx_reg[DATA_W-1];
                            tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                addr_q  <= addr_q + ADDR_W'(1);
                                load_tx <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_miso  = miso_q;
    assign bus.o_wr_n  = wr_n_q;
    assign bus.o_addr  = addr_q;
    assign bus.o_wdata = wdata_q;
    assign bus.o_busy  = busy_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: table vectors, mid-frame reset, idle noise and random frames
// checked against a frame-level model of registers and the address pointer.
module tb_spi_reg_bridge;
    localparam int ADDR_W = 3;

    typedef struct {
        logic [7:0]  cmd;
        int          ndata;
        logic [31:0] data;
        int          abort_bits;
        int          exp_writes;
        logic [11:0] exp_waddr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_addr;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    spi_reg_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(8)) bus ();

    spi_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(8), .BIT_CNT_W(3)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    // Downstream register file seen by the bridge, and the model's own copy of it.
    logic [7:0] mem     [0:7] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hC3, 8'hF5, 8'h06, 8'h17};
    logic [7:0] mem_ref [0:7] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hC3, 8'hF5, 8'h06, 8'h17};
    logic [2:0] model_addr = 3'd0;

    assign bus.i_rdata = mem[bus.o_addr];

    logic [2:0] wq_addr [$];
    logic [7:0] wq_data [$];
    int         width_err = 0;
    logic       prev_low  = 1'b0;

    always @(negedge i_clk) begin
        if (bus.o_wr_n === 1'b0) begin
            wq_addr.push_back(bus.o_addr);
            wq_data.push_back(bus.o_wdata);
            mem[bus.o_addr] = bus.o_wdata;
            if (prev_low) width_err++;
        end
        prev_low = (bus.o_wr_n === 1'b0);
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b, input bit cs_with_rise, output logic sampled);
        @(negedge i_clk);
        bus.i_sclk = 1'b0;
        bus.i_mosi = b;
        repeat (4) @(negedge i_clk);
        sampled = bus.o_miso;
        bus.i_sclk = 1'b1;
        if (cs_with_rise) bus.i_cs_n = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    logic [31:0] rx_bytes;
    logic        miso_cmd_or;
    logic        miso_all_or;

    task automatic applyStimulus(input logic [7:0] cmd, input int ndata, input logic [31:0] data,
                                 input int abort_bits);
        logic       s;
        logic [7:0] b;
        logic [7:0] rb;
        rx_bytes    = '0;
        miso_cmd_or = 1'b0;
        rb          = '0;
        @(negedge i_clk);
        bus.i_sclk = 1'b0;
        bus.i_cs_n = 1'b0;
        repeat (4) @(negedge i_clk);
        checkOutput("busy_on", 32'(bus.o_busy), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            sendBit(cmd[i], 1'b0, s);
            miso_cmd_or |= s;
        end
        miso_all_or = miso_cmd_or;
        for (int k = 0; k < ndata; k++) begin
            b = data[k*8 +: 8];
            for (int i = 7; i >= 0; i--) begin
                sendBit(b[i], 1'b0, s);
                rb[i] = s;
                miso_all_or |= s;
            end
            rx_bytes[k*8 +: 8] = rb;
        end
        if (abort_bits > 0) begin
            b = data[ndata*8 +: 8];
            for (int i = 0; i < abort_bits; i++) begin
                sendBit(b[7-i], (abort_bits == 8 && i == 7), s);
                miso_all_or |= s;
            end
        end
        @(negedge i_clk);
        bus.i_sclk = 1'b0;
        repeat (4) @(negedge i_clk);
        bus.i_cs_n = 1'b1;
        repeat (3) @(negedge i_clk);
        checkOutput("busy_off", 32'(bus.o_busy), 32'd0);
        repeat (4) @(negedge i_clk);
    endtask

    // Frame-level model: only complete data bytes count, each at the next address mod 8.
    task automatic modelFrame(input logic [7:0] cmd, input int ndata, input logic [31:0] data,
                              output int nw, output logic [11:0] wa, output logic [31:0] wd,
                              output logic [31:0] rd);
        nw = 0; wa = '0; wd = '0; rd = '0;
        model_addr = cmd[2:0];
        for (int k = 0; k < ndata; k++) begin
            if (cmd[7]) begin
                wa[k*3 +: 3]           = model_addr;
                wd[k*8 +: 8]           = data[k*8 +: 8];
                mem_ref[model_addr]    = data[k*8 +: 8];
                nw++;
            end else begin
                rd[k*8 +: 8] = mem_ref[model_addr];
            end
            model_addr = 3'((int'(model_addr) + 1) % 8);
        end
    endtask

    task automatic runFrame(input vec_t v, input bit use_tab);
        int          nw;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [2:0]  ea;
        modelFrame(v.cmd, v.ndata, v.data, nw, wa, wd, rd);
        ea = model_addr;
        if (use_tab) begin
            nw = v.exp_writes; wa = v.exp_waddr; wd = v.exp_wdata; rd = v.exp_rdata; ea = v.exp_addr;
        end
        wq_addr.delete();
        wq_data.delete();
        applyStimulus(v.cmd, v.ndata, v.data, v.abort_bits);
        checkOutput("strobe_count", 32'(wq_addr.size()), 32'(nw));
        for (int i = 0; i < nw && i < wq_addr.size(); i++) begin
            checkOutput("strobe_addr", 32'(wq_addr[i]), 32'(wa[i*3 +: 3]));
            checkOutput("strobe_data", 32'(wq_data[i]), 32'(wd[i*8 +: 8]));
        end
        checkOutput("final_addr", 32'(bus.o_addr), 32'(ea));
        if (v.cmd[7]) begin
            checkOutput("miso_write_frame", 32'(miso_all_or), 32'd0);
        end else begin
            checkOutput("miso_cmd_byte", 32'(miso_cmd_or), 32'd0);
            for (int k = 0; k < v.ndata; k++) begin
                checkOutput("miso_byte", 32'(rx_bytes[k*8 +: 8]), 32'(rd[k*8 +: 8]));
            end
        end
    endtask

    vec_t tab [7];
    vec_t v;
    logic s;
    int   noise_bad;
    logic [15:0] tail_bits;

    initial begin
        tab[0] = '{cmd:8'h82, ndata:1, data:32'h0000005A, abort_bits:0, exp_writes:1,
                   exp_waddr:{9'd0, 3'd2}, exp_wdata:32'h5A, exp_rdata:32'h0, exp_addr:3'd3};
        tab[1] = '{cmd:8'h04, ndata:1, data:32'h00000000, abort_bits:0, exp_writes:0,
                   exp_waddr:12'd0, exp_wdata:32'h0, exp_rdata:32'hC3, exp_addr:3'd5};
        tab[2] = '{cmd:8'h86, ndata:3, data:32'h00332211, abort_bits:0, exp_writes:3,
                   exp_waddr:{3'd0, 3'd0, 3'd7, 3'd6}, exp_wdata:32'h00332211, exp_rdata:32'h0, exp_addr:3'd1};
        tab[3] = '{cmd:8'h81, ndata:0, data:32'h000000A5, abort_bits:5, exp_writes:0,
                   exp_waddr:12'd0, exp_wdata:32'h0, exp_rdata:32'h0, exp_addr:3'd1};
        tab[4] = '{cmd:8'h81, ndata:1, data:32'h000000FF, abort_bits:0, exp_writes:1,
                   exp_waddr:{9'd0, 3'd1}, exp_wdata:32'hFF, exp_rdata:32'h0, exp_addr:3'd2};
        tab[5] = '{cmd:8'h85, ndata:0, data:32'h000000E7, abort_bits:8, exp_writes:0,
                   exp_waddr:12'd0, exp_wdata:32'h0, exp_rdata:32'h0, exp_addr:3'd5};
        tab[6] = '{cmd:8'h07, ndata:2, data:32'h0000FFFF, abort_bits:0, exp_writes:0,
                   exp_waddr:12'd0, exp_wdata:32'h0, exp_rdata:32'h00003322, exp_addr:3'd1};

        i_rst      = 1'b1;
        bus.i_cs_n = 1'b1;
        bus.i_sclk = 1'b0;
        bus.i_mosi = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_wr_n",  32'(bus.o_wr_n),  32'd1);
        checkOutput("rst_busy",  32'(bus.o_busy),  32'd0);
        checkOutput("rst_addr",  32'(bus.o_addr),  32'd0);
        checkOutput("rst_miso",  32'(bus.o_miso),  32'd0);
        checkOutput("rst_wdata", 32'(bus.o_wdata), 32'd0);
        i_rst = 1'b0;
        repeat (10) @(negedge i_clk);

        for (int t = 0; t < 7; t++) runFrame(tab[t], 1'b1);

        // Reset during data bit 3 of a write while CS stays low, then keep clocking.
        wq_addr.delete();
        wq_data.delete();
        @(negedge i_clk);
        bus.i_cs_n = 1'b0;
        repeat (4) @(negedge i_clk);
        for (int i = 7; i >= 0; i--) sendBit(1'(8'h83 >> i), 1'b0, s);
        for (int i = 7; i >= 5; i--) sendBit(1'(8'h77 >> i), 1'b0, s);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("midrst_busy",  32'(bus.o_busy),  32'd0);
        checkOutput("midrst_wr_n",  32'(bus.o_wr_n),  32'd1);
        checkOutput("midrst_addr",  32'(bus.o_addr),  32'd0);
        checkOutput("midrst_miso",  32'(bus.o_miso),  32'd0);
        checkOutput("midrst_wdata", 32'(bus.o_wdata), 32'd0);
        i_rst = 1'b0;
        model_addr = 3'd0;
        tail_bits = 16'hB799;
        for (int i = 15; i >= 0; i--) sendBit(tail_bits[i], 1'b0, s);
        @(negedge i_clk);
        bus.i_sclk = 1'b0;
        repeat (4) @(negedge i_clk);
        checkOutput("postrst_strobes", 32'(wq_addr.size()), 32'd0);
        checkOutput("postrst_busy",    32'(bus.o_busy),      32'd0);
        checkOutput("postrst_addr",    32'(bus.o_addr),      32'd0);
        bus.i_cs_n = 1'b1;
        repeat (8) @(negedge i_clk);
        v = '{cmd:8'h80, ndata:1, data:32'h3C, abort_bits:0, exp_writes:1,
              exp_waddr:12'd0, exp_wdata:32'h3C, exp_rdata:32'h0, exp_addr:3'd1};
        runFrame(v, 1'b1);

        // SCLK/MOSI activity with CS high must do nothing.
        wq_addr.delete();
        wq_data.delete();
        noise_bad = 0;
        for (int e = 0; e < 64; e++) begin
            @(negedge i_clk);
            bus.i_sclk = ~bus.i_sclk;
            bus.i_mosi = 1'($urandom);
            repeat (3) begin
                @(negedge i_clk);
                if (bus.o_busy !== 1'b0 || bus.o_miso !== 1'b0) noise_bad++;
            end
        end
        checkOutput("noise_flags",   32'(noise_bad),         32'd0);
        checkOutput("noise_strobes", 32'(wq_addr.size()),    32'd0);
        checkOutput("noise_addr",    32'(bus.o_addr),        32'd1);

        for (int r = 0; r < 24; r++) begin
            v.cmd        = 8'($urandom);
            v.ndata      = int'($urandom_range(1, 3));
            v.data       = $urandom;
            v.abort_bits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            runFrame(v, 1'b0);
        end

        checkOutput("strobe_width", 32'(width_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
